// File: rtl/shift_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_ctrl_if : word-in / result-out handshake bundle for shift_ctrl |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface shift_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_err;

   // slave is the controller side; master is the producer/consumer environment
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_err
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_err
   );
endinterface
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_ctrl : serialises a word MSB-first into an external shift      |
// | register, reads it back in parallel and flags readback mismatches.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_ctrl_if.slave      bus,
   input  logic             abort,
   output logic             sr_d,
   output logic             sr_en,
   input  logic [WIDTH-1:0] sr_q
);

   localparam int            CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_SHIFT   = 2'd1;
   localparam logic [1:0] c_CAPTURE = 2'd2;
   localparam logic [1:0] c_DONE    = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_err;
   logic             r_armed;
   logic [CW-1:0]    w_idx;
   logic             w_accept;

   // r_armed keeps in_ready low until the first edge after reset release
   assign bus.in_ready  = r_armed && (r_state == c_IDLE) && !abort;
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_idx         = c_LAST - r_cnt;
   assign sr_en         = (r_state == c_SHIFT);
   assign sr_d          = sr_en & r_word[w_idx];
   assign bus.out_valid = (r_state == c_DONE);
   assign bus.out_data  = r_out_data;
   assign bus.out_err   = r_out_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_word     <= '0;
         r_out_data <= '0;
         r_out_err  <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (abort) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_out_err <= 1'b0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (w_accept) begin
                     r_word  <= bus.in_data;
                     r_cnt   <= '0;
                     r_state <= c_SHIFT;
                  end
               end
               c_SHIFT: begin
                  if (r_cnt == c_LAST) begin
                     r_cnt   <= '0;
                     r_state <= c_CAPTURE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               c_CAPTURE: begin
                  r_out_data <= sr_q;
                  r_out_err  <= (sr_q != r_word);
                  r_state    <= c_DONE;
               end
               c_DONE: begin
                  if (bus.out_ready) begin
                     r_state <= c_IDLE;
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the word and of the controlled shift register (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  WIDTH  parallel word to be shifted out.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_ready  output  1  the controller accepts a word this cycle.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-008 SHALL have port sr_d  output  1  serial data driven to the shift register d input.
REQ-009 SHALL have port sr_en  output  1  shift enable/clock-qualify for the shift register.
REQ-010 SHALL have port sr_q  input  WIDTH  parallel readback of the shift register q.
REQ-011 SHALL have port out_data  output  WIDTH  captured shift-register contents.
REQ-012 SHALL have port out_valid  output  1  out_data and out_err are valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-014 SHALL have port out_err  output  1  readback mismatch against the accepted word.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, CAPTURE and DONE.
REQ-016 SHALL assert in_ready only in IDLE with abort low.
REQ-017 SHALL accept a word on a rising edge with in_valid=1 and in_ready=1: it latches in_data into an internal word register, clears the bit counter to 0 and enters SHIFT.
REQ-018 In SHIFT, SHALL drive sr_en=1 and sr_d=word[WIDTH-1-cnt] (MSB first), incrementing cnt on each edge.
REQ-019 SHALL leave SHIFT for CAPTURE on the edge where cnt=WIDTH-1, giving exactly WIDTH cycles with sr_en=1.
REQ-020 The shift register shifts q <= {q[WIDTH-2:0], d} when sr_en=1, so after WIDTH shifts sr_q equals the accepted word.
REQ-021 In CAPTURE, for exactly one cycle, SHALL drive sr_en=0 and register out_data<=sr_q and out_err<=(sr_q != word) on the exit edge to DONE.
REQ-022 In DONE, SHALL hold out_valid=1 with stable out_data and out_err until an edge with out_ready=1, then return to IDLE.
REQ-023 out_valid SHALL rise WIDTH+1 edges after the accept edge (5 edges for WIDTH=4).
REQ-024 If out_ready is held high, back-to-back words SHALL be accepted every WIDTH+3 cycles; in_ready stays low in DONE even when out_ready=1.
REQ-025 Outside SHIFT, sr_en SHALL be 0 and sr_d SHALL be 0.
REQ-026 in_valid outside IDLE SHALL be ignored; in_data changes after accept SHALL NOT affect the shifted word.
REQ-027 abort=1 on an edge in any state SHALL force IDLE with cnt=0, out_valid=0 and out_err=0; abort has priority over accept and over out_ready.
REQ-028 out_data SHALL retain its last captured value after leaving DONE.

Reset
REQ-029 While rst_n=0, SHALL immediately force state IDLE, cnt=0, word=0, out_data=0, out_valid=0, out_err=0, sr_en=0, sr_d=0 and in_ready=0, independent of clk.
REQ-030 in_ready SHALL rise only after the first rising edge following rst_n deassertion.
REQ-031 Reset asserted mid-SHIFT SHALL drop sr_en within the same cycle, and no partial result SHALL be presented afterward.

Verification
REQ-032 Bench case: WIDTH=4, reset, send 4'b1011 with an external shift register model and out_ready=1 -> sr_d sequence 1,0,1,1 over 4 sr_en cycles; out_valid 5 edges after accept; out_data=4'b1011; out_err=0.
REQ-033 Bench case: send 4'b0110 with out_ready=0 for 10 cycles -> out_valid and out_data stable for 10 cycles; in_ready=0 throughout; IDLE on the first edge with out_ready=1.
REQ-034 Bench case: send 4'b1111 with the model's q[2] forced to 0 -> out_data=4'b1011 and out_err=1.
REQ-035 Bench case: abort on the 2nd SHIFT cycle of 4'b1001 -> sr_en=0 next cycle, out_valid never rises, in_ready=1 next cycle; a following 4'b0101 completes correctly.
REQ-036 Bench case: rst_n pulsed low asynchronously mid-SHIFT -> all outputs go to 0 without a clock edge; the next word completes normally.
REQ-037 Bench case: stream 4'b0001, 4'b1000, 4'b1010 back-to-back with in_valid and out_ready held high -> accepts 7 cycles apart; outputs match inputs in order with out_err=0.
